// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC register, IF/ID register, a one-entry
// hold buffer for responses that arrive while decode is stalled, and a drop
// state that absorbs a response still owed to memory after a redirect.
// Optional: define FETCH_PERF_EN to add the perf_stall_cnt output (cycles with
// stall asserted or a bubble written into IF/ID, saturating).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        if_vld_q, if_vld_d;

    // Request intent before reset gating; flops ignore D while in reset, so the
    // acceptance term can use this ungated version.
    logic        req_raw;
    logic        accept;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;  // 32-bit modulo, 0xFFFF_FFFC wraps to 0

    // Request outputs: held low while reset is asserted so an abandoned request
    // drops immediately, and raised in the first cycle after release.
    always_comb begin
        req_raw   = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            S_FETCH: begin
                req_raw   = 1'b1;
                imem_addr = pc_q;
            end
            S_HOLD: begin
                req_raw   = 1'b0;
                imem_addr = pc_q;
            end
            S_DROP: begin
                // Keep the abandoned address stable until memory answers.
                req_raw   = 1'b1;
                imem_addr = drop_addr_q;
            end
            default: begin
                req_raw   = 1'b0;
                imem_addr = pc_q;
            end
        endcase
        imem_req = req_raw & rst_n;
    end

    assign accept = req_raw & imem_ready;

    // Next-state, PC, hold buffer and IF/ID update; flush outranks stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        hold_vld_d   = hold_vld_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        if_vld_d     = if_vld_q;

        case (state_q)
            S_FETCH: begin
                if (flush) begin
                    pc_d       = branch_target;
                    if_instr_d = 32'h0;
                    if_vld_d   = 1'b0;
                    hold_vld_d = 1'b0;
                    if (!accept) begin
                        // Memory still owes us a word for pc_q; swallow it.
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end else if (accept) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        hold_vld_d   = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc4_d   = pc_plus4;
                        if_vld_d   = 1'b1;
                    end
                end else if (!stall) begin
                    // No word this cycle: present a bubble, keep pc_plus4.
                    if_instr_d = 32'h0;
                    if_vld_d   = 1'b0;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    pc_d       = branch_target;
                    if_instr_d = 32'h0;
                    if_vld_d   = 1'b0;
                    hold_vld_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    if_instr_d = hold_instr_q;
                    if_pc4_d   = hold_pc4_q;
                    if_vld_d   = hold_vld_q;
                    hold_vld_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end

            S_DROP: begin
                if (flush) begin
                    pc_d       = branch_target;
                    if_instr_d = 32'h0;
                    if_vld_d   = 1'b0;
                    hold_vld_d = 1'b0;
                end else if (!stall) begin
                    if_instr_d = 32'h0;
                    if_vld_d   = 1'b0;
                end
                // The owed response is discarded; resume fetching at pc_q.
                if (accept) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d    = S_FETCH;
                hold_vld_d = 1'b0;
            end
        endcase
    end

    // State, PC and hold buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
            hold_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            hold_vld_q   <= hold_vld_d;
        end
    end

    // IF/ID pipeline register presented to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_instr_q <= 32'h0;
            if_pc4_q   <= 32'h0;
            if_vld_q   <= 1'b0;
        end else begin
            if_instr_q <= if_instr_d;
            if_pc4_q   <= if_pc4_d;
            if_vld_q   <= if_vld_d;
        end
    end

    assign if_id_instr    = if_instr_q;
    assign if_id_pc_plus4 = if_pc4_q;
    assign if_id_valid    = if_vld_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        perf_event;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A bubble is any IF/ID load without a valid word: flush, or an unstalled
    // cycle whose new IF/ID content is invalid.
    always_comb begin
        perf_event = stall | flush | (~stall & ~if_vld_d);
        perf_d     = perf_event ? sat_inc(perf_q) : perf_q;
    end

    // Stall/bubble cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 32'h0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, reset-mid-request sequence,
// and a randomized run checked against a program-order delivery model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        pre_req;
    logic [31:0] pre_addr;

    // Memory contents as a function of word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, sample request side before the edge,
    // then sample IF/ID 1ns after the rising edge.
    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t);
        @(negedge clk);
        stall         = s;
        flush         = f;
        imem_ready    = r;
        branch_target = t;
        imem_rdata    = r ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        #1;
        pre_req  = imem_req;
        pre_addr = imem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ready = 1'b0;
        branch_target = 32'h0;
        imem_rdata = 32'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic        s;
        logic        f;
        logic        r;
        logic [31:0] tgt;
        logic        e_req;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] tgt,
                                input logic e_req, input logic chk_addr, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc4);
        vec_t v;
        v.s        = s;
        v.f        = f;
        v.r        = r;
        v.tgt      = tgt;
        v.e_req    = e_req;
        v.chk_addr = chk_addr;
        v.e_addr   = e_addr;
        v.e_vld    = e_vld;
        v.e_instr  = e_vld ? mem_word(e_pc4 - 32'd4) : 32'h0;
        v.e_pc4    = e_pc4;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Directed table: start-up stream, stall/hold, bubble, flush cases, wrap.
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h0,        1,32'h4));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h4,        1,32'h8));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h8,        1,32'hC));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'hC,        1,32'h10));
        tbl.push_back(mk(1,0,1,32'h0,        1,1,32'h10,       1,32'h10));
        tbl.push_back(mk(1,0,1,32'h0,        0,0,32'h0,        1,32'h10));
        tbl.push_back(mk(1,0,1,32'h0,        0,0,32'h0,        1,32'h10));
        tbl.push_back(mk(0,0,1,32'h0,        0,0,32'h0,        1,32'h14));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h14,       1,32'h18));
        tbl.push_back(mk(0,0,0,32'h0,        1,1,32'h18,       0,32'h18));
        tbl.push_back(mk(1,0,0,32'h0,        1,1,32'h18,       0,32'h18));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h18,       1,32'h1C));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h1C,       1,32'h20));
        tbl.push_back(mk(0,1,0,32'h100,      1,1,32'h20,       0,32'h20));
        tbl.push_back(mk(0,0,0,32'h0,        1,1,32'h20,       0,32'h20));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h20,       0,32'h20));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h100,      1,32'h104));
        tbl.push_back(mk(1,1,1,32'h200,      1,1,32'h104,      0,32'h104));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h200,      1,32'h204));
        tbl.push_back(mk(1,0,1,32'h0,        1,1,32'h204,      1,32'h204));
        tbl.push_back(mk(1,1,1,32'h300,      0,0,32'h0,        0,32'h204));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h300,      1,32'h304));
        tbl.push_back(mk(0,1,0,32'h400,      1,1,32'h304,      0,32'h304));
        tbl.push_back(mk(0,1,0,32'h500,      1,1,32'h304,      0,32'h304));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h304,      0,32'h304));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h500,      1,32'h504));
        tbl.push_back(mk(0,1,1,32'hFFFF_FFFC,1,1,32'h504,      0,32'h504));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'hFFFF_FFFC,1,32'h0));
        tbl.push_back(mk(0,0,1,32'h0,        1,1,32'h0,        1,32'h4));

        // Reset state.
        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ready = 1'b1;
        branch_target = 32'h0;
        imem_rdata = 32'h1234_5678;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_req",   imem_req,       32'h0);
        check("rst_addr",  imem_addr,      32'h0);
        check("rst_instr", if_id_instr,    32'h0);
        check("rst_pc4",   if_id_pc_plus4, 32'h0);
        check("rst_vld",   if_id_valid,    32'h0);
        @(negedge clk);
        imem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_req",  imem_req,  32'h1);
        check("rel_addr", imem_addr, 32'h0);

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].f, tbl[i].r, tbl[i].tgt);
            check($sformatf("vec%0d_req", i), pre_req, tbl[i].e_req);
            if (tbl[i].chk_addr) check($sformatf("vec%0d_addr", i), pre_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_vld", i),   if_id_valid,    tbl[i].e_vld);
            check($sformatf("vec%0d_instr", i), if_id_instr,    tbl[i].e_instr);
            check($sformatf("vec%0d_pc4", i),   if_id_pc_plus4, tbl[i].e_pc4);
        end

        // Reset pulsed while a request waits; the stale word must never appear.
        step(0, 0, 0, 32'h0);
        @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req",   imem_req,       32'h0);
        check("midrst_vld",   if_id_valid,    32'h0);
        check("midrst_instr", if_id_instr,    32'h0);
        check("midrst_pc4",   if_id_pc_plus4, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_edge_vld", if_id_valid, 32'h0);
        @(negedge clk);
        imem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("midrst_rel_req",  imem_req,  32'h1);
        check("midrst_rel_addr", imem_addr, 32'h0);
        step(0, 0, 1, 32'h0);
        check("midrst_first_addr",  pre_addr,       32'h0);
        check("midrst_first_vld",   if_id_valid,    32'h1);
        check("midrst_first_instr", if_id_instr,    mem_word(32'h0));
        check("midrst_first_pc4",   if_id_pc_plus4, 32'h4);

        // Randomized run against a program-order model: every delivered word is
        // the next sequential address since reset or the latest flush target.
        begin
            logic [31:0] exp_pc;
            logic        p_req, p_ready, have_prev;
            logic [31:0] p_addr, p_instr, p_pc4;
            logic        p_vld;
            int          deliveries;
            logic        s, f, r;
            logic [31:0] t;

            do_reset();
            exp_pc     = 32'h0;
            have_prev  = 1'b0;
            p_req      = 1'b0;
            p_ready    = 1'b0;
            p_addr     = 32'h0;
            p_instr    = 32'h0;
            p_pc4      = 32'h0;
            p_vld      = 1'b0;
            deliveries = 0;

            for (int c = 0; c < 2000; c++) begin
                s = ($urandom_range(0, 99) < 25);
                f = ($urandom_range(0, 99) < 6);
                r = ($urandom_range(0, 99) < 65);
                t = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
                step(s, f, r, t);

                if (have_prev && p_req && !p_ready) begin
                    check("rnd_hs_req",  pre_req,  32'h1);
                    check("rnd_hs_addr", pre_addr, p_addr);
                end

                if (f) begin
                    check("rnd_flush_vld",   if_id_valid, 32'h0);
                    check("rnd_flush_instr", if_id_instr, 32'h0);
                    exp_pc = t;
                end else if (s) begin
                    check("rnd_stall_vld",   if_id_valid,    p_vld);
                    check("rnd_stall_instr", if_id_instr,    p_instr);
                    check("rnd_stall_pc4",   if_id_pc_plus4, p_pc4);
                end else if (if_id_valid) begin
                    check("rnd_instr", if_id_instr,    mem_word(exp_pc));
                    check("rnd_pc4",   if_id_pc_plus4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    deliveries++;
                end else begin
                    check("rnd_bubble_instr", if_id_instr,    32'h0);
                    check("rnd_bubble_pc4",   if_id_pc_plus4, p_pc4);
                end

                have_prev = 1'b1;
                p_req     = pre_req;
                p_ready   = r;
                p_addr    = pre_addr;
                p_instr   = if_id_instr;
                p_pc4     = if_id_pc_plus4;
                p_vld     = if_id_valid;
            end
            check("rnd_progress", (deliveries > 100) ? 32'h1 : 32'h0, 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
